// File: rtl/cla_pipe_adder32_pkg.sv
// Shared widths, the per-byte propagate/generate pair and the byte lookahead
// helper for the pipelined carry-lookahead adder.
package cla_pipe_adder32_pkg;

  localparam int WIDTH   = 32;
  localparam int GROUP_W = 8;
  localparam int NGROUPS = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_pair_t;

  // Group P is the AND of bit propagates; group G folds from the LSB up so the
  // highest generating bit with an unbroken propagate chain above it wins.
  function automatic pg_pair_t group_pg(input logic [GROUP_W-1:0] p,
                                        input logic [GROUP_W-1:0] g);
    pg_pair_t r;
    r.p = &p;
    r.g = 1'b0;
    for (int i = 0; i < GROUP_W; i++) begin
      r.g = g[i] | (p[i] & r.g);
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_carry_unit.sv
// Four-group carry lookahead: produces the carry out of every byte group
// directly from group P/G and the carry-in, with no ripple between groups.
module cla_carry_unit
  import cla_pipe_adder32_pkg::*;
(
  input  logic [NGROUPS-1:0] group_g,
  input  logic [NGROUPS-1:0] group_p,
  input  logic               cin,
  output logic               c8,
  output logic               c16,
  output logic               c24,
  output logic               c32
);

  assign c8  = group_g[0]
             | (group_p[0] & cin);

  assign c16 = group_g[1]
             | (group_p[1] & group_g[0])
             | (group_p[1] & group_p[0] & cin);

  assign c24 = group_g[2]
             | (group_p[2] & group_g[1])
             | (group_p[2] & group_p[1] & group_g[0])
             | (group_p[2] & group_p[1] & group_p[0] & cin);

  assign c32 = group_g[3]
             | (group_p[3] & group_g[2])
             | (group_p[3] & group_p[2] & group_g[1])
             | (group_p[3] & group_p[2] & group_p[1] & group_g[0])
             | (group_p[3] & group_p[2] & group_p[1] & group_p[0] & cin);

endmodule

// File: rtl/cla_pipe_adder32.sv
// Two-stage valid/ready 32-bit add/subtract: S1 registers bit and byte P/G,
// S2 registers the lookahead result together with carry, overflow and group P/G.
module cla_pipe_adder32
  import cla_pipe_adder32_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  input  logic               c_in,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               c_out,
  output logic               overflow,
  output logic [NGROUPS-1:0] group_p,
  output logic [NGROUPS-1:0] group_g
);

  logic                      s1_valid;
  logic [WIDTH-1:0]          s1_p;
  logic [WIDTH-1:0]          s1_g;
  logic                      s1_cin;
  pg_pair_t [NGROUPS-1:0]    s1_grp;

  logic                      s1_adv;
  logic                      s2_adv;
  logic [WIDTH-1:0]          b_eff;
  logic [WIDTH-1:0]          p_in;
  logic [WIDTH-1:0]          g_in;
  pg_pair_t [NGROUPS-1:0]    grp_in;
  logic [NGROUPS-1:0]        s1_gp;
  logic [NGROUPS-1:0]        s1_gg;
  logic                      c8, c16, c24, c32;
  logic [NGROUPS-1:0]        grp_cin;
  logic [WIDTH-1:0]          sum_n;
  logic                      c31_n;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign b_eff = sub ? ~data_b : data_b;
  assign p_in  = data_a ^ b_eff;
  assign g_in  = data_a & b_eff;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grp_in = '0;
    for (int k = 0; k < NGROUPS; k++) begin
      grp_in[k] = group_pg(p_in[k*GROUP_W +: GROUP_W], g_in[k*GROUP_W +: GROUP_W]);
    end
  end

  // NOTE: only the valid flag needs reset; payload registers are qualified by it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (s1_adv && in_valid) begin
      s1_p   <= p_in;
      s1_g   <= g_in;
      s1_cin <= sub | c_in;
      s1_grp <= grp_in;
    end
  end

  always_comb begin
    s1_gp = '0;
    s1_gg = '0;
    for (int k = 0; k < NGROUPS; k++) begin
      s1_gp[k] = s1_grp[k].p;
      s1_gg[k] = s1_grp[k].g;
    end
  end

  cla_carry_unit u_carry (
    .group_g (s1_gg),
    .group_p (s1_gp),
    .cin     (s1_cin),
    .c8      (c8),
    .c16     (c16),
    .c24     (c24),
    .c32     (c32)
  );

  assign grp_cin = {c24, c16, c8, s1_cin};

  // NOTE: the carry variable is scratch logic inside the block, so blocking '=' is correct here.
  always_comb begin
    logic c;
    sum_n = '0;
    c31_n = 1'b0;
    c     = 1'b0;
    for (int k = 0; k < NGROUPS; k++) begin
      c = grp_cin[k];
      for (int i = 0; i < GROUP_W; i++) begin
        sum_n[k*GROUP_W + i] = s1_p[k*GROUP_W + i] ^ c;
        if (k*GROUP_W + i == WIDTH - 1) c31_n = c;
        c = s1_g[k*GROUP_W + i] | (s1_p[k*GROUP_W + i] & c);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      group_p   <= '0;
      group_g   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum      <= sum_n;
        c_out    <= c32;
        overflow <= c31_n ^ c32;
        group_p  <= s1_gp;
        group_g  <= s1_gg;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder32.sv
// Self-checking bench for cla_pipe_adder32: directed vector table, stall and
// reset sequences, then a random valid/ready run against an arithmetic model.
module tb_cla_pipe_adder32;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        c_out;
  logic        overflow;
  logic [3:0]  group_p;
  logic [3:0]  group_g;

  cla_pipe_adder32 dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_a    (data_a),
    .data_b    (data_b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .group_p   (group_p),
    .group_g   (group_g)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] sum;
    logic        c_out;
    logic        overflow;
    logic [3:0]  gp;
    logic [3:0]  gg;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference: whole-word arithmetic; byte G is the carry out of the byte sum
  // with no carry-in, byte P is "every bit of the byte propagates".
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sb);
    res_t        r;
    logic [31:0] bb;
    logic        ci;
    logic [32:0] full;
    logic [8:0]  bs;
    bb         = sb ? ~b : b;
    ci         = sb ? 1'b1 : cin;
    full       = {1'b0, a} + {1'b0, bb} + {32'd0, ci};
    r.sum      = full[31:0];
    r.c_out    = full[32];
    r.overflow = (a[31] == bb[31]) && (full[31] != a[31]);
    for (int k = 0; k < 4; k++) begin
      bs      = {1'b0, a[k*8 +: 8]} + {1'b0, bb[k*8 +: 8]};
      r.gg[k] = bs[8];
      r.gp[k] = ((a[k*8 +: 8] ^ bb[k*8 +: 8]) == 8'hFF);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    check({tag, "_sum"},  sum,            e.sum);
    check({tag, "_cout"}, 32'(c_out),     32'(e.c_out));
    check({tag, "_ovf"},  32'(overflow),  32'(e.overflow));
    check({tag, "_gp"},   32'(group_p),   32'(e.gp));
    check({tag, "_gg"},   32'(group_g),   32'(e.gg));
  endtask

  task automatic set_beat(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sb);
    in_valid = 1'b1;
    data_a   = a;
    data_b   = b;
    c_in     = cin;
    sub      = sb;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard, active only during the random phase.
  bit          sb_en = 1'b0;
  res_t        sb_q[$];
  res_t        exp_r;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_sum;
  logic [5:0]  prev_flags;

  always @(negedge clock) begin
    if (sb_en && !reset) begin
      if (prev_hold) begin
        check("stall_hold_sum", sum, prev_sum);
        check("stall_hold_flags", 32'({c_out, overflow, group_p}), 32'(prev_flags));
      end
      prev_hold  = out_valid && !out_ready;
      prev_sum   = sum;
      prev_flags = {c_out, overflow, group_p};
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_spurious_beat", 32'd1, 32'd0);
        end else begin
          exp_r = sb_q.pop_front();
          check_res("sb", exp_r);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(data_a, data_b, c_in, sub));
      check("sb_inflight_le2", 32'(sb_q.size() <= 2), 32'd1);
    end
  end

  vec_t vecs[7];
  res_t zero_r;
  res_t r0, r1, r2;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 4'hE, 4'h1}};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 4'h6, 4'h1}};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 4'hE, 4'h0}};
    vecs[3] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, '{32'h0100_0100, 1'b0, 1'b0, 4'h0, 4'h5}};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, '{32'h2345_678A, 1'b0, 1'b0, 4'h0, 4'h0}};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 4'h6, 4'h8}};
    vecs[6] = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 4'hF, 4'h0}};
    zero_r  = '{32'h0, 1'b0, 1'b0, 4'h0, 4'h0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data_a = '0; data_b = '0; c_in = 1'b0; sub = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check_res("rst", zero_r);
    @(posedge clock); #1 reset = 1'b0;

    // Directed table: accept edge, then the result is visible after the next edge.
    foreach (vecs[i]) begin
      set_beat(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      @(negedge clock);
      check("dir_in_ready", 32'(in_ready), 32'd1);
      check("dir_idle_out_valid", 32'(out_valid), 32'd0);
      @(posedge clock); #1 in_valid = 1'b0;
      @(negedge clock);
      check("dir_lat1_out_valid", 32'(out_valid), 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      check("dir_lat2_out_valid", 32'(out_valid), 32'd1);
      check_res($sformatf("dir%0d", i), vecs[i].exp);
      @(posedge clock); #1;
    end

    // Three back-to-back beats with the consumer stalled for three edges.
    r0 = model(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
    r1 = model(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    r2 = model(32'hFFFF_0000, 32'h0001_FFFF, 1'b0, 1'b0);
    set_beat(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
    @(negedge clock);
    check("stl_in_ready0", 32'(in_ready), 32'd1);
    @(posedge clock); #1 set_beat(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    @(negedge clock);
    check("stl_in_ready1", 32'(in_ready), 32'd1);
    check("stl_out_valid1", 32'(out_valid), 32'd0);
    @(posedge clock); #1 set_beat(32'hFFFF_0000, 32'h0001_FFFF, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("stl_hold_valid", 32'(out_valid), 32'd1);
      check("stl_hold_in_ready", 32'(in_ready), 32'd0);
      check_res("stl_hold", r0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("stl_release_in_ready", 32'(in_ready), 32'd1);
    check_res("stl_b0", r0);
    @(posedge clock); #1 in_valid = 1'b0;
    @(negedge clock);
    check("stl_b1_valid", 32'(out_valid), 32'd1);
    check_res("stl_b1", r1);
    @(posedge clock); #1;
    @(negedge clock);
    check("stl_b2_valid", 32'(out_valid), 32'd1);
    check_res("stl_b2", r2);
    @(posedge clock); #1;
    @(negedge clock);
    check("stl_drained", 32'(out_valid), 32'd0);

    // Reset with two beats in flight.
    @(posedge clock); #1 set_beat(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(posedge clock); #1 set_beat(32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0);
    @(posedge clock); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    check("rp_pre_valid", 32'(out_valid), 32'd1);
    check("rp_pre_in_ready", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("rp_out_valid", 32'(out_valid), 32'd0);
    check("rp_in_ready", 32'(in_ready), 32'd1);
    check_res("rp", zero_r);
    @(posedge clock); #1 reset = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("rp_no_stale", 32'(out_valid), 32'd0);
      @(posedge clock); #1;
    end

    // Random valid/ready traffic against the scoreboard.
    sb_en = 1'b1;
    for (int n = 0; n < 500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      data_a    = rand_op();
      data_b    = rand_op();
      c_in      = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && (sb_q.size() != 0 || out_valid); t++) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("sb_drain_empty", 32'(sb_q.size()), 32'd0);
    check("sb_drain_valid", 32'(out_valid), 32'd0);
    sb_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
